level_meter: RTL and testbench

LEVEL_METER -- requirements
Module: level_meter

---
 rtl/level_meter_pkg.sv | 27 ++
 rtl/level_abs.sv | 55 +++++
 rtl/level_meter.sv | 181 ++++++++++++++++++
 tb/tb_level_meter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/level_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : level_meter_pkg
//  Description : Shared constants and helpers for the level_meter block.
//                LEVEL_W      - width of the published level word.
//                abs_sample() - unsigned magnitude of a sign-extended sample.
//  Revision    : 1.0 - initial release
// ============================================================================
package level_meter_pkg;

    localparam int unsigned LEVEL_W = 32;

    // Input is a sample already sign-extended to LEVEL_W bits, so the most
    // negative SAMPLE_W value maps to 2**(SAMPLE_W-1) without wrapping. The
    // caller truncates the result back to SAMPLE_W bits, which is exact.
    function automatic logic [LEVEL_W-1:0] abs_sample(input logic signed [LEVEL_W-1:0] x);
        logic [LEVEL_W-1:0] mag;
        if (x[LEVEL_W-1]) begin
            mag = ~x + LEVEL_W'(1);
        end else begin
            mag = x;
        end
        return mag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/level_abs.sv
`default_nettype none
// ============================================================================
//  Module      : level_abs
//  Description : First pipeline stage of level_meter. Registers the unsigned
//                magnitude of the incoming sample together with its valid and
//                end-of-window flags.
//  Ports       : clk            - system clock (rising edge)
//                rst            - synchronous active-high reset
//                clear_i        - drop the sample presented this cycle
//                sample_i       - signed two's-complement sample
//                sample_valid_i - sample_i qualified this cycle
//                last_i         - this accepted sample closes the window
//                abs_o          - registered |sample|
//                valid_o        - registered qualifier
//                last_o         - registered end-of-window flag
//  Revision    : 1.0 - initial release
// ============================================================================
module level_abs
    import level_meter_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic                       sample_valid_i,
    input  logic                       last_i,
    output logic        [SAMPLE_W-1:0] abs_o,
    output logic                       valid_o,
    output logic                       last_o
);

    logic [SAMPLE_W-1:0] abs_q;
    logic                valid_q;
    logic                last_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            abs_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            abs_q   <= SAMPLE_W'(abs_sample(LEVEL_W'(sample_i)));
            valid_q <= sample_valid_i;
            last_q  <= last_i;
        end
    end

    assign abs_o   = abs_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;

endmodule
`default_nettype wire

// File: rtl/level_meter.sv
`default_nettype none
// ============================================================================
//  Module      : level_meter
//  Description : Windowed audio level meter. Sums |sample| (and optionally
//                tracks max |sample|) over windows of 2**WINDOW_LOG2 accepted
//                samples and publishes the result with a one-cycle pulse,
//                two cycles after the window's final sample.
//  Config      : LEVEL_METER_PEAK_EN - when defined, peak tracking is built
//                and drives peak_o; otherwise peak_o is constant zero.
//  Ports       : clk            - system clock (rising edge)
//                rst            - synchronous active-high reset
//                sample_i       - signed audio sample
//                sample_valid_i - sample_i qualified this cycle
//                clear_i        - restart the partial window
//                level_o        - sum of |sample| over last window
//                peak_o         - max |sample| over last window
//                level_valid_o  - one-cycle pulse on level/peak update
//  Revision    : 1.0 - initial release
// ============================================================================
module level_meter
    import level_meter_pkg::*;
#(
    parameter int unsigned SAMPLE_W    = 16,
    parameter int unsigned WINDOW_LOG2 = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic                       sample_valid_i,
    input  logic                       clear_i,
    output logic        [LEVEL_W-1:0]  level_o,
    output logic        [SAMPLE_W-1:0] peak_o,
    output logic                       level_valid_o
);

    localparam int unsigned ACC_W = SAMPLE_W + WINDOW_LOG2;

    generate
        if (ACC_W > LEVEL_W) begin : g_width_check
            $error("level_meter: SAMPLE_W + WINDOW_LOG2 must not exceed 32");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sample counter: clear discards the sample of the same cycle.
    // ------------------------------------------------------------------
    logic [WINDOW_LOG2-1:0] cnt_q;
    logic [WINDOW_LOG2-1:0] cnt_d;
    logic                   accept;
    logic                   last_d;

    assign accept = sample_valid_i && !clear_i;
    assign last_d = accept && (cnt_q == '1);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (sample_valid_i) begin
            cnt_d = cnt_q + WINDOW_LOG2'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1
    // ------------------------------------------------------------------
    logic [SAMPLE_W-1:0] abs_q;
    logic                valid_q;
    logic                last_q;

    level_abs #(
        .SAMPLE_W (SAMPLE_W)
    ) u_abs (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (clear_i),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .last_i         (last_d),
        .abs_o          (abs_q),
        .valid_o        (valid_q),
        .last_o         (last_q)
    );

    // ------------------------------------------------------------------
    // Stage 2: accumulate and publish. A completion already in this stage
    // still publishes when clear_i is high; clear only wipes the partials.
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [ACC_W-1:0]   sum;
    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] level_d;
    logic               lvalid_q;
    logic               lvalid_d;

    assign sum = acc_q + ACC_W'(abs_q);

    always_comb begin
        acc_d    = acc_q;
        level_d  = level_q;
        lvalid_d = 1'b0;
        if (valid_q) begin
            if (last_q) begin
                level_d  = LEVEL_W'(sum);
                acc_d    = '0;
                lvalid_d = 1'b1;
            end else begin
                acc_d = sum;
            end
        end
        if (clear_i) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            level_q  <= '0;
            lvalid_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            level_q  <= level_d;
            lvalid_q <= lvalid_d;
        end
    end

    assign level_o       = level_q;
    assign level_valid_o = lvalid_q;

`ifdef LEVEL_METER_PEAK_EN
    logic [SAMPLE_W-1:0] pk_q;
    logic [SAMPLE_W-1:0] pk_d;
    logic [SAMPLE_W-1:0] pk_max;
    logic [SAMPLE_W-1:0] peak_q;
    logic [SAMPLE_W-1:0] peak_d;

    assign pk_max = (abs_q > pk_q) ? abs_q : pk_q;

    always_comb begin
        pk_d   = pk_q;
        peak_d = peak_q;
        if (valid_q) begin
            if (last_q) begin
                peak_d = pk_max;
                pk_d   = '0;
            end else begin
                pk_d = pk_max;
            end
        end
        if (clear_i) begin
            pk_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pk_q   <= '0;
            peak_q <= '0;
        end else begin
            pk_q   <= pk_d;
            peak_q <= peak_d;
        end
    end

    assign peak_o = peak_q;
`else
    assign peak_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_level_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_level_meter
//  Description : Directed self-checking bench for level_meter with
//                SAMPLE_W=16, WINDOW_LOG2=2 (four-sample windows). Expected
//                peak values follow LEVEL_METER_PEAK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_level_meter;

    localparam int unsigned SAMPLE_W    = 16;
    localparam int unsigned WINDOW_LOG2 = 2;

`ifdef LEVEL_METER_PEAK_EN
    localparam bit PEAK_ON = 1'b1;
`else
    localparam bit PEAK_ON = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic signed [SAMPLE_W-1:0] sample_i = '0;
    logic                       sample_valid_i = 1'b0;
    logic                       clear_i = 1'b0;
    logic        [31:0]         level_o;
    logic        [SAMPLE_W-1:0] peak_o;
    logic                       level_valid_o;

    int n_cmp  = 0;
    int n_err  = 0;
    int pulses = 0;
    int p0;

    level_meter #(
        .SAMPLE_W    (SAMPLE_W),
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .clear_i        (clear_i),
        .level_o        (level_o),
        .peak_o         (peak_o),
        .level_valid_o  (level_valid_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (level_valid_o === 1'b1) pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int x);
        sample_i       = SAMPLE_W'(x);
        sample_valid_i = 1'b1;
        @(posedge clk);
        #1;
        sample_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pk(input int v);
        return PEAK_ON ? 32'(v) : 32'd0;
    endfunction

    // Called right after the window's final sample was sampled: one cycle
    // later nothing yet, two cycles after it the pulse, then quiet + hold.
    task automatic window_check(input string tag, input int exp_level, input int exp_peak);
        chk({tag, "_early"}, 32'(level_valid_o), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 32'(level_valid_o), 32'd1);
        chk({tag, "_level"}, level_o, 32'(exp_level));
        chk({tag, "_peak"}, 32'(peak_o), pk(exp_peak));
        @(posedge clk);
        #1;
        chk({tag, "_after"}, 32'(level_valid_o), 32'd0);
        chk({tag, "_hold"}, level_o, 32'(exp_level));
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        idle(3);
        chk("rst_level", level_o, 32'd0);
        chk("rst_peak", 32'(peak_o), 32'd0);
        chk("rst_valid", 32'(level_valid_o), 32'd0);
        rst = 1'b0;
        idle(1);

        // Mixed-sign back-to-back window
        p0 = pulses;
        send(1); send(-2); send(3); send(-4);
        window_check("mix", 10, 4);
        chk("mix_pulses", 32'(pulses - p0), 32'd1);

        // Most negative sample magnitude
        p0 = pulses;
        send(-32768); send(-32768); send(-32768); send(-32768);
        window_check("minneg", 131072, 32768);
        chk("minneg_pulses", 32'(pulses - p0), 32'd1);

        // Clear concurrent with a sample discards partial window and sample
        p0 = pulses;
        send(5); send(5);
        clear_i        = 1'b1;
        sample_i       = SAMPLE_W'(100);
        sample_valid_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i        = 1'b0;
        sample_valid_i = 1'b0;
        chk("clr_level_hold", level_o, 32'd131072);
        chk("clr_peak_hold", 32'(peak_o), pk(32768));
        send(1); send(1); send(1); send(1);
        window_check("clr", 4, 1);
        chk("clr_pulses", 32'(pulses - p0), 32'd1);

        // Idle gaps between samples
        p0 = pulses;
        send(7); idle(3);
        send(0); idle(3);
        send(0); idle(3);
        send(9);
        window_check("gap", 16, 9);
        chk("gap_pulses", 32'(pulses - p0), 32'd1);

        // Reset mid-window
        p0 = pulses;
        send(50); send(60);
        rst = 1'b1;
        idle(1);
        chk("midrst_level", level_o, 32'd0);
        chk("midrst_peak", 32'(peak_o), 32'd0);
        idle(1);
        chk("midrst_valid", 32'(level_valid_o), 32'd0);
        rst = 1'b0;
        idle(2);
        chk("midrst_nopulse", 32'(pulses - p0), 32'd0);
        send(2); send(2); send(2); send(2);
        window_check("postrst", 8, 2);
        chk("postrst_pulses", 32'(pulses - p0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
